// File: rtl/aes_gcm_pkg.sv
// Shared definitions for the AES-GCM GHASH/tag path: block kinds,
// reduction constant and controller state encoding.
package aes_gcm_pkg;

  localparam logic [1:0] KIND_AAD = 2'b00;
  localparam logic [1:0] KIND_CT  = 2'b01;
  localparam logic [1:0] KIND_LEN = 2'b10;

  localparam logic [0:127] GCM_R_POLY = 128'he1000000000000000000000000000000;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    MUL,
    FINAL,
    OUT
  } state_t;

endpackage

// File: rtl/gf128_mul_serial.sv
// Bit-serial GF(2^128) multiplier in GCM bit order: one bit of X per cycle,
// result presented combinationally alongside done on the final step.
module gf128_mul_serial
  import aes_gcm_pkg::*;
#(
  parameter logic [0:127] R_POLY    = GCM_R_POLY,
  parameter int unsigned  MUL_STEPS = 128
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [0:127] x_in,
  input  logic [0:127] h_in,
  output logic         done,
  output logic [0:127] result
);

  localparam int unsigned CW = $clog2(MUL_STEPS);
  localparam logic [CW-1:0] LAST = CW'(MUL_STEPS - 1);

  logic [0:127]  x_reg, z_reg, v_reg;
  logic [0:127]  z_next, v_next;
  logic [CW-1:0] cnt;
  logic          active;

  // V >> 1 moves bits toward higher GCM index, i.e. multiplies by x.
  always_comb begin
    z_next = x_reg[cnt] ? (z_reg ^ v_reg) : z_reg;
    v_next = v_reg[127] ? ((v_reg >> 1) ^ R_POLY) : (v_reg >> 1);
  end

  always_ff @(posedge clock) begin
    if (reset || abort) begin
      x_reg  <= '0;
      z_reg  <= '0;
      v_reg  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      x_reg  <= x_in;
      z_reg  <= '0;
      v_reg  <= h_in;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      z_reg <= z_next;
      v_reg <= v_next;
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) active <= 1'b0;
    end
  end

  assign done   = active && (cnt == LAST);
  assign result = z_next;

endmodule

// File: rtl/aes_gcm_ghash_tag.sv
// GHASH accumulator and tag generator: folds AAD/CT/LEN blocks into Y with
// a serial multiplier, then emits Y ^ E(K,J0) on a valid/ready handshake.
module aes_gcm_ghash_tag
  import aes_gcm_pkg::*;
#(
  parameter logic [0:127] R_POLY    = GCM_R_POLY,
  parameter int unsigned  MUL_STEPS = 128
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [0:127] h_in,
  input  logic         h_valid,
  input  logic         clear_h,
  input  logic [0:127] in_data,
  input  logic [1:0]   in_kind,
  input  logic         in_valid,
  output logic         ready_for_inp,
  input  logic [0:127] ekj0,
  input  logic         ekj0_valid,
  output logic [0:127] tag,
  output logic         tag_valid,
  input  logic         ready_to_out,
  output logic         busy
);

  state_t       state, state_next;
  logic [0:127] h_reg, y_reg, tag_reg;
  logic         tag_valid_reg;
  logic         last_flag;
  logic         in_fire;
  logic         mul_start, mul_done;
  logic [0:127] mul_result;

  assign in_fire   = in_valid && ready_for_inp;
  assign mul_start = in_fire && !clear_h;

  gf128_mul_serial #(
    .R_POLY    (R_POLY),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clock  (clock),
    .reset  (reset),
    .start  (mul_start),
    .abort  (clear_h),
    .x_in   (y_reg ^ in_data),
    .h_in   (h_reg),
    .done   (mul_done),
    .result (mul_result)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear_h) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (h_valid)      state_next = ACCEPT;
        ACCEPT:  if (in_valid)     state_next = MUL;
        MUL:     if (mul_done)     state_next = last_flag ? FINAL : ACCEPT;
        FINAL:   if (ekj0_valid)   state_next = OUT;
        OUT:     if (ready_to_out) state_next = ACCEPT;
        default:                   state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_for_inp = 1'b0;
    busy          = 1'b0;
    case (state)
      ACCEPT:     ready_for_inp = 1'b1;
      MUL, FINAL: busy          = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_reg         <= '0;
      y_reg         <= '0;
      tag_reg       <= '0;
      tag_valid_reg <= 1'b0;
      last_flag     <= 1'b0;
    end else if (clear_h) begin
      h_reg         <= '0;
      y_reg         <= '0;
      tag_valid_reg <= 1'b0;
      last_flag     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (h_valid) begin
          h_reg <= h_in;
          y_reg <= '0;
        end
        ACCEPT: if (in_valid) last_flag <= (in_kind == KIND_LEN);
        MUL: if (mul_done) y_reg <= mul_result;
        FINAL: if (ekj0_valid) begin
          tag_reg       <= y_reg ^ ekj0;
          tag_valid_reg <= 1'b1;
        end
        OUT: if (ready_to_out) begin
          tag_valid_reg <= 1'b0;
          y_reg         <= '0;
        end
        default: ;
      endcase
    end
  end

  assign tag       = tag_reg;
  assign tag_valid = tag_valid_reg;

endmodule

// File: tb/tb_aes_gcm_ghash_tag.sv
// Self-checking bench for aes_gcm_ghash_tag using GCM test cases 13/14/16,
// backpressure, clear_h and reset scenarios with a tag scoreboard.
module tb_aes_gcm_ghash_tag;

  logic         clock = 1'b0;
  logic         reset;
  logic [127:0] h_in;
  logic         h_valid;
  logic         clear_h;
  logic [127:0] in_data;
  logic [1:0]   in_kind;
  logic         in_valid;
  logic         ready_for_inp;
  logic [127:0] ekj0;
  logic         ekj0_valid;
  logic [127:0] tag;
  logic         tag_valid;
  logic         ready_to_out;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;
  logic [127:0] sb[$];

  localparam logic [127:0] H13   = 128'hdc95c078a2408989ad48a21492842087;
  localparam logic [127:0] EK13  = 128'h530f8afbc74536b9a963b4f1c4cb738b;
  localparam logic [127:0] CT14  = 128'hcea7403d4d606b6e074ec5d3baf39d18;
  localparam logic [127:0] LEN14 = 128'h00000000000000000000000000000080;
  localparam logic [127:0] TAG14 = 128'hd0d1c8a799996bf0265b98b5d48ab919;
  localparam logic [127:0] H16   = 128'hacbef20579b4b8ebce889bac8732dad7;
  localparam logic [127:0] TAG16 = 128'h76fc6ece0f4e1768cddf8853bb2d551b;

  always #5 clock = ~clock;

  aes_gcm_ghash_tag dut (
    .clock         (clock),
    .reset         (reset),
    .h_in          (h_in),
    .h_valid       (h_valid),
    .clear_h       (clear_h),
    .in_data       (in_data),
    .in_kind       (in_kind),
    .in_valid      (in_valid),
    .ready_for_inp (ready_for_inp),
    .ekj0          (ekj0),
    .ekj0_valid    (ekj0_valid),
    .tag           (tag),
    .tag_valid     (tag_valid),
    .ready_to_out  (ready_to_out),
    .busy          (busy)
  );

  // Reference GF(2^128) product: carry-less multiply on bit-reflected
  // polynomials, then reduce by x^128 + x^7 + x^2 + x + 1.
  function automatic logic [127:0] gmul_ref(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] ra, rb, res;
    logic [254:0] p;
    for (int k = 0; k < 128; k++) begin
      ra[k] = a[127-k];
      rb[k] = b[127-k];
    end
    p = '0;
    for (int i = 0; i < 128; i++)
      if (rb[i]) p = p ^ ({127'b0, ra} << i);
    for (int k = 254; k >= 128; k--) begin
      if (p[k]) begin
        p[k] = 1'b0;
        p[k-121] = ~p[k-121];
        p[k-126] = ~p[k-126];
        p[k-127] = ~p[k-127];
        p[k-128] = ~p[k-128];
      end
    end
    for (int k = 0; k < 128; k++) res[127-k] = p[k];
    return res;
  endfunction

  task automatic load_h(input logic [127:0] h);
    @(negedge clock);
    clear_h = 1'b1;
    @(posedge clock); #1 clear_h = 1'b0;
    h_in = h; h_valid = 1'b1;
    @(posedge clock); #1 h_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d, input logic [1:0] k, input bit check_gap);
    int unsigned n;
    bit got;
    int low;
    n = 0; got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clock);
      if (ready_for_inp) got = 1'b1;
      else n++;
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: ready_for_inp never rose for block %h", d);
      return;
    end
    in_data = d; in_kind = k; in_valid = 1'b1;
    @(posedge clock); #1 in_valid = 1'b0; in_data = '0;
    if (check_gap) begin
      low = 0;
      @(negedge clock);
      while (!ready_for_inp && low < 300) begin
        low++;
        @(negedge clock);
      end
      vectors++;
      if (low !== 128) begin
        miscompares++;
        $display("FAIL ready_gap: low for %0d cycles, required 128", low);
      end
    end
  endtask

  task automatic collect_tag(input int hold);
    int unsigned n;
    logic [127:0] exp;
    bit stable;
    n = 0;
    while (!tag_valid && n < 400) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: tag %h with nothing expected", tag);
      return;
    end
    exp = sb.pop_front();
    if (!tag_valid) begin
      miscompares++;
      $display("FAIL tag_timeout: tag_valid=0, required 1 (expected tag %h)", exp);
      return;
    end
    if (tag !== exp) begin
      miscompares++;
      $display("FAIL tag_value: got %h, required %h", tag, exp);
    end
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clock);
        if (tag_valid !== 1'b1 || tag !== exp) stable = 1'b0;
      end
      vectors++;
      if (!stable) begin
        miscompares++;
        $display("FAIL tag_hold: tag_valid=%b tag=%h, required 1/%h", tag_valid, tag, exp);
      end
    end
    @(negedge clock);
    ready_to_out = 1'b1;
    @(posedge clock); #1 ready_to_out = 1'b0;
    @(negedge clock);
    vectors++;
    if (tag_valid !== 1'b0 || ready_for_inp !== 1'b1) begin
      miscompares++;
      $display("FAIL tag_release: tag_valid=%b ready_for_inp=%b, required 0/1", tag_valid, ready_for_inp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    vectors++;
    if ({ready_for_inp, tag_valid, busy} !== 3'b000 || tag !== '0) begin
      miscompares++;
      $display("FAIL reset_state: rdy=%b tv=%b busy=%b tag=%h, required 0 0 0 0",
               ready_for_inp, tag_valid, busy, tag);
    end
  endtask

  task automatic test_tc13();
    load_h(H13);
    @(negedge clock);
    vectors++;
    if (ready_for_inp !== 1'b1) begin
      miscompares++;
      $display("FAIL h_load_accept: ready_for_inp=%b, required 1", ready_for_inp);
    end
    ekj0 = EK13; ekj0_valid = 1'b0;
    send_block('0, 2'b10, 1'b0);
    sb.push_back(EK13);
    repeat (135) @(negedge clock);
    vectors++;
    if (busy !== 1'b1 || tag_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL final_wait: busy=%b tag_valid=%b, required 1/0", busy, tag_valid);
    end
    ekj0_valid = 1'b1;
    collect_tag(0);
  endtask

  task automatic test_tc14(input int hold);
    ekj0 = EK13; ekj0_valid = 1'b1;
    send_block(CT14, 2'b01, 1'b1);
    send_block(LEN14, 2'b10, 1'b0);
    sb.push_back(TAG14);
    collect_tag(hold);
  endtask

  task automatic test_tc16();
    logic [127:0] blk[7];
    logic [1:0]   knd[7];
    logic [127:0] y;
    blk[0] = 128'hfeedfacedeadbeeffeedfacedeadbeef; knd[0] = 2'b00;
    blk[1] = 128'habaddad2000000000000000000000000; knd[1] = 2'b11;
    blk[2] = 128'h522dc1f099567d07f47f37a32a84427d; knd[2] = 2'b01;
    blk[3] = 128'h643a8cdcbfe5c0c97598a2bd2555d1aa; knd[3] = 2'b01;
    blk[4] = 128'h8cb08e48590dbb3da7b08b1056828838; knd[4] = 2'b01;
    blk[5] = 128'hc5f61e6393ba7a0abcc9f66200000000; knd[5] = 2'b01;
    blk[6] = 128'h00000000000000a000000000000001e0; knd[6] = 2'b10;
    y = '0;
    for (int i = 0; i < 7; i++) y = gmul_ref(y ^ blk[i], H16);
    ekj0 = TAG16 ^ y; ekj0_valid = 1'b1;
    load_h(H16);
    for (int i = 0; i < 7; i++) send_block(blk[i], knd[i], (i == 2));
    sb.push_back(TAG16);
    collect_tag(0);
  endtask

  task automatic test_clear_h();
    bit bad;
    load_h(H16);
    send_block(128'h0123456789abcdef0123456789abcdef, 2'b00, 1'b0);
    repeat (50) @(negedge clock);
    clear_h = 1'b1;
    @(posedge clock); #1 clear_h = 1'b0;
    @(negedge clock);
    vectors++;
    if ({ready_for_inp, busy, tag_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL clear_mid_mul: rdy=%b busy=%b tv=%b, required 0 0 0", ready_for_inp, busy, tag_valid);
    end
    bad = 1'b0;
    in_data = CT14; in_kind = 2'b01; in_valid = 1'b1;
    repeat (140) begin
      @(negedge clock);
      if (ready_for_inp || busy) bad = 1'b1;
    end
    in_valid = 1'b0;
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL no_accept_idle: input accepted without H (rdy=%b busy=%b), required none",
               ready_for_inp, busy);
    end
    h_in = H13; h_valid = 1'b1; clear_h = 1'b1;
    @(posedge clock); #1 h_valid = 1'b0; clear_h = 1'b0;
    @(negedge clock);
    vectors++;
    if (ready_for_inp !== 1'b0) begin
      miscompares++;
      $display("FAIL hv_and_clear: ready_for_inp=%b, required 0", ready_for_inp);
    end
    h_in = H13; h_valid = 1'b1;
    @(posedge clock); #1 h_valid = 1'b0;
    test_tc14(0);
  endtask

  task automatic test_reset_in_out();
    int unsigned n;
    load_h(H13);
    ekj0 = EK13; ekj0_valid = 1'b1;
    send_block('0, 2'b10, 1'b0);
    n = 0;
    while (!tag_valid && n < 400) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (tag_valid !== 1'b1 || tag !== EK13) begin
      miscompares++;
      $display("FAIL reach_out: tv=%b tag=%h, required 1/%h", tag_valid, tag, EK13);
    end
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (tag !== '0 || {tag_valid, ready_for_inp, busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_in_out: tag=%h tv=%b rdy=%b busy=%b, required 0 0 0 0",
               tag, tag_valid, ready_for_inp, busy);
    end
  endtask

  initial begin
    reset = 1'b0; h_in = '0; h_valid = 1'b0; clear_h = 1'b0;
    in_data = '0; in_kind = 2'b00; in_valid = 1'b0;
    ekj0 = '0; ekj0_valid = 1'b0; ready_to_out = 1'b0;
    test_reset();
    test_tc13();
    load_h(H13);
    test_tc14(0);
    test_tc14(20);
    test_tc16();
    test_clear_h();
    test_reset_in_out();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: %0d tags outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
